// File: rtl/tape_mem_arbiter_if.sv
// One requester's tape port: a one-cycle access pulse goes in; a one-cycle ack and held read data come out.
interface tape_mem_arbiter_if #(
  parameter int ADDR_W = 10
) ();
  logic              access;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        wdata;
  logic [1:0]        rdata;
  logic              ack;

  modport master (output access, rw, addr, wdata, input rdata, ack);
  modport slave  (input access, rw, addr, wdata, output rdata, ack);
endinterface

// File: rtl/tape_mem_arbiter.sv
// Tape memory owner: round-robin share of one access port between tm/ed/lcd, plus a full blank sweep.
// Uncontended pulses are served in their own cycle (ack/rdata next cycle); losers wait in a last-wins pending slot.
module tape_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tape_clear,
  output logic              busy,
  tape_mem_arbiter_if.slave tm,
  tape_mem_arbiter_if.slave ed,
  tape_mem_arbiter_if.slave lcd
);
  localparam int         NP    = 3;
  localparam logic [1:0] P_LCD = 2'd2;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        wdata;
  } req_t;

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [1:0]        last_grant;
  logic [NP-1:0]     pend_vld;
  req_t              pend_req [NP];
  logic [NP-1:0]     ack_q;
  logic [1:0]        rdata_q  [NP];

  logic [NP-1:0]     live_vld;
  req_t              live_req [NP];
  logic [NP-1:0]     cand_vld;
  req_t              cand_req [NP];
  logic              gnt_vld;
  logic [1:0]        gnt_idx;
  req_t              gnt_req;
  logic              serve;

  logic [1:0]        mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [1:0]        mem_wdata;

  assign live_vld    = {lcd.access, ed.access, tm.access};
  assign live_req[0] = {tm.rw, tm.addr, tm.wdata};
  assign live_req[1] = {ed.rw, ed.addr, ed.wdata};
  assign live_req[2] = {lcd.rw, lcd.addr, lcd.wdata};

  // A live pulse always supersedes whatever the same port left pending.
  always_comb begin
    cand_vld = live_vld | pend_vld;
    for (int p = 0; p < NP; p++) begin
      cand_req[p] = live_vld[p] ? live_req[p] : pend_req[p];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_grant;
    gnt_req = '0;
    for (int off = 1; off <= NP; off++) begin
      if (!gnt_vld && cand_vld[(int'(last_grant) + off) % NP]) begin
        gnt_vld = 1'b1;
        gnt_idx = 2'((int'(last_grant) + off) % NP);
        gnt_req = cand_req[(int'(last_grant) + off) % NP];
      end
    end
  end

  assign serve = (state == ST_RUN) && gnt_vld;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = gnt_req.addr;
    mem_wdata = gnt_req.wdata;
    if (state == ST_SWEEP) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_cnt;
      mem_wdata = 2'b00;
    end else if (serve && !gnt_req.rw) begin
      mem_we = 1'b1;
    end
  end

  // Tape cells carry no reset; the post-reset sweep defines them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_SWEEP;
      sweep_cnt  <= '0;
      busy       <= 1'b1;
      last_grant <= P_LCD;
      pend_vld   <= '0;
      ack_q      <= '0;
      for (int p = 0; p < NP; p++) begin
        pend_req[p] <= '0;
        rdata_q[p]  <= 2'b00;
      end
    end else begin
      ack_q <= '0;
      case (state)
        ST_SWEEP: begin
          for (int p = 0; p < NP; p++) begin
            if (live_vld[p]) begin
              pend_vld[p] <= 1'b1;
              pend_req[p] <= live_req[p];
            end
          end
          if (tape_clear) begin
            sweep_cnt <= '0;
          end else if (sweep_cnt == ADDR_W'(DEPTH - 1)) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        default: begin
          for (int p = 0; p < NP; p++) begin
            if (serve && gnt_idx == 2'(p)) begin
              pend_vld[p] <= 1'b0;
              ack_q[p]    <= 1'b1;
              if (gnt_req.rw) begin
                rdata_q[p] <= mem[gnt_req.addr];
              end
            end else if (live_vld[p]) begin
              pend_vld[p] <= 1'b1;
              pend_req[p] <= live_req[p];
            end
          end
          if (gnt_vld) begin
            last_grant <= gnt_idx;
          end
          // The access served alongside a clear still completes; the sweep starts next cycle.
          if (tape_clear) begin
            state     <= ST_SWEEP;
            sweep_cnt <= '0;
            busy      <= 1'b1;
          end
        end
      endcase
    end
  end

  assign tm.ack    = ack_q[0];
  assign ed.ack    = ack_q[1];
  assign lcd.ack   = ack_q[2];
  assign tm.rdata  = rdata_q[0];
  assign ed.rdata  = rdata_q[1];
  assign lcd.rdata = rdata_q[2];

endmodule

// File: doc/tape_mem_arbiter.md
# tape_mem_arbiter

Owns the Turing machine's 1024-symbol tape memory and shares its single access port between three requesters: the Turing step engine (tm), the keyboard tape editor (ed) and the LCD interface tape display (lcd). Requests are one-cycle access pulses, arbitrated round-robin and served in the same cycle when uncontended. Read data is returned one cycle after the pulse, which meets the LCD interface's two-tick sampling window. The block also performs a full-tape blank sweep after reset and on command.

## Interface
- ADDR_W, 10, tape address width.
- DEPTH, 1024, number of tape cells; equals 2^ADDR_W.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- tape_clear  in  1  one-cycle pulse; blank-sweeps the whole tape.
- busy  out  1  high while a sweep is running.
- For each port p in {tm, ed, lcd}:
  - p_access  in  1  one-cycle request pulse.
  - p_rw  in  1  1 = read, 0 = write.
  - p_addr  in  ADDR_W  cell address.
  - p_wdata  in  2  symbol to write.
  - p_rdata  out  2  read data; holds its value until that port's next read completes.
  - p_ack  out  1  one-cycle pulse marking completion.
- Symbol encoding: 00 blank, 01 zero, 10 one, 11 hash.

## Operation
- **Storage.** DEPTH x 2-bit register array, not reset.
- **Pending registers.** Each port has a pending register {valid, rw, addr, wdata}.
  - A port's candidate is its live pulse if p_access is high; otherwise it is the pending entry.
  - A new pulse while an entry is pending overwrites that entry; the last request wins and only one ack is produced.
- **Arbitration.** In each non-sweep cycle, exactly one candidate is served, chosen by round-robin.
  - Search starts at the port after last_grant, in the order tm -> ed -> lcd -> tm.
  - last_grant updates to the served port.
  - Losing live pulses are latched into their pending registers. The served port's pending entry is cleared.
- **Service.**
  - Read: mem[addr] is loaded into p_rdata at the serving edge.
  - Write: mem[addr] <= wdata at the serving edge; p_rdata is unchanged.
  - Both cases: p_ack is high during the next cycle.
- **States.** SWEEP and RUN.
  - SWEEP: a counter runs 0..DEPTH-1 and writes 00 to one cell per cycle. No requests are served; pulses are latched as pending. After cell DEPTH-1 the block goes to RUN, and busy falls in the cycle after the last write.
  - RUN: normal arbitration. A tape_clear pulse moves the block to SWEEP with the counter at 0. Any request served in that same cycle completes normally.
  - tape_clear during SWEEP restarts the counter at 0.
- **Address rule.** Addresses are unsigned ADDR_W bits and wrap modulo DEPTH. The LCD's head_loc-8 underflow wraps to the top of the tape; no error is raised.

## Timing
- **Reset values.**
  - state = SWEEP, counter = 0, busy = 1.
  - All p_ack = 0 and all p_rdata = 00.
  - All pending entries invalid; last_grant = lcd, so tm has first priority.
- **Sweep duration.** An automatic sweep starts on reset release and takes DEPTH cycles.
- **Uncontended latency.** A pulse in cycle N is served at the end of N; ack and rdata are valid in cycle N+1.
- **Contended latency.** Worst case, a request is served at the end of cycle N+2, with ack in N+3.
- **Reset mid-operation.** Pending entries and acks are discarded and a new sweep starts. Tape contents are undefined until that sweep completes.
- **Same address.** If a write and a read to the same address are pending, they serialise in grant order. A read served after the write returns the new symbol.
- **Sweep/request boundary.** A request pulsed during the final sweep cycle is served in the first RUN cycle.

## Test plan
- **Reset sweep.** Release rst, then hold lcd_access low. busy stays high for exactly 1024 cycles. Afterwards, a read of addr 0x3FF gives lcd_rdata = 00 and lcd_ack one cycle after the pulse.
- **Uncontended write/read.** tm writes 10 to 0x005 in cycle N; tm_ack is high in N+1. lcd reads 0x005 in N+3; lcd_rdata = 10 is valid in N+4.
- **Three-way collision.** tm, ed and lcd all pulse in cycle N with last_grant = lcd. Acks arrive in order tm (N+1), ed (N+2), lcd (N+3). A repeat collision starts with lcd's successor, tm.
- **Overwrite while pending.** Block ed behind tm and lcd. ed pulses a read of 0x010, then a read of 0x011 while the first is pending. Exactly one ed_ack occurs, and ed_rdata = mem[0x011].
- **Clear mid-run.** Write 11 to 0x200, then pulse tape_clear. busy goes high for 1024 cycles. A tm read pulsed during the sweep is acked after busy falls, with data 00.
- **Address wrap.** lcd reads address 0x3F8 (head 0 - 8). It gets the cell at 0x3F8, and no other cell is touched.
